stream_select_mux: RTL and testbench

- Parametrised successor to the 2:1 selectors: an N-channel, W-bit-wide stream multiplexer with valid/ready handshakes and a registered output stage.
- Two modes:
  - fixed: an explicit select input picks the channel.
  - round-robin: fair arbitration among channels with valid data.
- Sits between multiple producers (ALU result, memory read, immediate paths) and a single downstream consumer.

---
 rtl/stream_select_mux_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 42 ++++
 rtl/stream_select_mux.sv | 134 +++++++++++++
 tb/tb_stream_select_mux.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/stream_select_mux_pkg.sv
// Shared constants and helpers for the stream select multiplexer.
// Optional packet lock is enabled with STREAM_SELECT_MUX_PKT_LOCK_EN.
package stream_select_mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Channel index reached by stepping 'off' places past 'base', wrapping at n.
    function automatic int wrap_idx(input int base, input int off, input int n);
        int s;
        s = base + off;
        return (s >= n) ? s - n : s;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the pointer upward with wrap and
// owns the pointer, which moves just past the granted channel on advance.
module rr_arbiter
    import stream_select_mux_pkg::*;
#(
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] req,
    input  logic                advance,
    output logic [SEL_W-1:0]    grant_idx,
    output logic                grant_valid
);

    logic [SEL_W-1:0] ptr_q, ptr_d;

    // Walk from the farthest offset down so the nearest requester wins.
    always_comb begin
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (req[wrap_idx(int'(ptr_q), i, CHANNELS)]) begin
                grant_idx   = SEL_W'(wrap_idx(int'(ptr_q), i, CHANNELS));
                grant_valid = 1'b1;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && grant_valid)
            ptr_d = (int'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + SEL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) ptr_q <= '0;
        else     ptr_q <= ptr_d;
    end

endmodule

// File: rtl/stream_select_mux.sv
// N-channel valid/ready stream mux with fixed-select or round-robin grant
// and one registered output stage. STREAM_SELECT_MUX_PKT_LOCK_EN adds packet lock.
module stream_select_mux
    import stream_select_mux_pkg::*;
#(
    parameter  int WIDTH    = 16,
    parameter  int CHANNELS = 4,
    localparam int SEL_W    = $clog2(CHANNELS)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      mode,
    input  logic [SEL_W-1:0]          sel,
    input  logic [CHANNELS*WIDTH-1:0] in_data,
    input  logic [CHANNELS-1:0]       in_valid,
    output logic [CHANNELS-1:0]       in_ready,
    output logic [WIDTH-1:0]          out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [SEL_W-1:0]          out_chan
`ifdef STREAM_SELECT_MUX_PKT_LOCK_EN
    ,
    input  logic [CHANNELS-1:0]       in_last,
    output logic                      out_last
`endif
);

    logic [WIDTH-1:0]    out_data_q, out_data_d;
    logic                out_valid_q, out_valid_d;
    logic [SEL_W-1:0]    out_chan_q, out_chan_d;
    logic                load, accept, grant_valid, fixed_ok;
    logic                rr_valid, rr_advance;
    logic [SEL_W-1:0]    g, rr_idx;
    logic [CHANNELS-1:0] rr_req;

`ifdef STREAM_SELECT_MUX_PKT_LOCK_EN
    logic                lock_q, lock_d;
    logic [SEL_W-1:0]    lock_chan_q, lock_chan_d;
    logic                out_last_q, out_last_d;
`endif

    rr_arbiter #(.CHANNELS(CHANNELS)) u_arb (
        .clk         (clk),
        .rst         (rst),
        .req         (rr_req),
        .advance     (rr_advance),
        .grant_idx   (rr_idx),
        .grant_valid (rr_valid)
    );

    // Grant selection. Fixed mode looks only at in_valid[sel], so ready
    // never depends on the other channels.
    always_comb begin
        load     = !out_valid_q || out_ready;
        rr_req   = in_valid;
        fixed_ok = (int'(sel) < CHANNELS) && in_valid[sel];
        g           = sel;
        grant_valid = fixed_ok;
        if (mode == MODE_RR) begin
            g           = rr_idx;
            grant_valid = rr_valid;
        end
`ifdef STREAM_SELECT_MUX_PKT_LOCK_EN
        // Masking the arbiter to the locked channel keeps its grant index
        // equal to that channel, so the release advance lands just past it.
        if (lock_q) begin
            rr_req      = in_valid & (CHANNELS'(1) << lock_chan_q);
            g           = lock_chan_q;
            grant_valid = in_valid[lock_chan_q];
        end
`endif
        accept   = !rst && load && grant_valid;
        in_ready = '0;
        if (accept) in_ready[g] = 1'b1;
        rr_advance = accept && (mode == MODE_RR);
`ifdef STREAM_SELECT_MUX_PKT_LOCK_EN
        rr_advance = rr_advance && in_last[g];
`endif
    end

    always_comb begin
        out_valid_d = accept || (out_valid_q && !out_ready);
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        if (accept) begin
            out_data_d = in_data[int'(g)*WIDTH +: WIDTH];
            out_chan_d = g;
        end
    end

`ifdef STREAM_SELECT_MUX_PKT_LOCK_EN
    always_comb begin
        lock_d      = lock_q;
        lock_chan_d = lock_chan_q;
        out_last_d  = out_last_q;
        if (accept) begin
            lock_d      = !in_last[g];
            lock_chan_d = g;
            out_last_d  = in_last[g];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q      <= 1'b0;
            lock_chan_q <= '0;
            out_last_q  <= 1'b0;
        end else begin
            lock_q      <= lock_d;
            lock_chan_q <= lock_chan_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_last = out_last_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule

// File: tb/tb_stream_select_mux.sv
// Directed self-checking bench for stream_select_mux (WIDTH=16, CHANNELS=4);
// covers the packet-lock path when STREAM_SELECT_MUX_PKT_LOCK_EN is defined.
module tb_stream_select_mux;

    localparam int WIDTH    = 16;
    localparam int CHANNELS = 4;

    logic        clk = 1'b0;
    logic        rst, mode, out_valid, out_ready;
    logic [1:0]  sel, out_chan;
    logic [63:0] in_data;
    logic [3:0]  in_valid, in_ready;
    logic [15:0] out_data;
`ifdef STREAM_SELECT_MUX_PKT_LOCK_EN
    logic [3:0]  in_last;
    logic        out_last;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    stream_select_mux #(.WIDTH(WIDTH), .CHANNELS(CHANNELS)) dut (
        .clk       (clk),
        .rst       (rst),
        .mode      (mode),
        .sel       (sel),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_chan  (out_chan)
`ifdef STREAM_SELECT_MUX_PKT_LOCK_EN
        ,
        .in_last   (in_last),
        .out_last  (out_last)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string tag, input int v, input int d, input int c);
        check({tag, ".valid"}, 32'(out_valid), 32'(v));
        check({tag, ".data"},  32'(out_data),  32'(d));
        check({tag, ".chan"},  32'(out_chan),  32'(c));
    endtask

    initial begin
        for (int i = 0; i < CHANNELS; i++) in_data[i*WIDTH +: WIDTH] = 16'(16'h1000 + i);
        rst = 1'b1; mode = 1'b0; sel = 2'd0; in_valid = 4'hF; out_ready = 1'b1;
`ifdef STREAM_SELECT_MUX_PKT_LOCK_EN
        in_last = 4'h0;
`endif
        // Reset: no ready during reset, output cleared
        step();
        check("rst_ready", 32'(in_ready), 32'h0);
        step();
        check_out("rst", 0, 0, 0);
        in_valid = 4'h0; rst = 1'b0;
        step();
        check("idle_valid", 32'(out_valid), 32'h0);

        // Fixed select, channel 2
        mode = 1'b0; sel = 2'd2; in_valid = 4'b0110; in_data[2*WIDTH +: WIDTH] = 16'hBEEF;
        #1 check("fix2_ready", 32'(in_ready), 32'h4);
        step();
        check_out("fix2", 1, 32'hBEEF, 2);
        in_valid = 4'h0;
        #1 check("fix2_noready", 32'(in_ready), 32'h0);
        step();
        check_out("fix2_drain", 0, 32'hBEEF, 2);

        // Round robin, all channels valid: 0,1,2,3,0
        in_data[2*WIDTH +: WIDTH] = 16'h1002;
        mode = 1'b1; in_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            #1 check("rr_ready", 32'(in_ready), 32'(1 << (k % 4)));
            step();
            check_out("rr", 1, 32'h1000 + (k % 4), k % 4);
        end

        // Backpressure for three cycles holds the ch0 beat
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 check("bp_ready", 32'(in_ready), 32'h0);
            step();
            check_out("bp_hold", 1, 32'h1000, 0);
        end
        out_ready = 1'b1;
        #1 check("bp_release_ready", 32'(in_ready), 32'h2);
        step();
        check_out("bp_release", 1, 32'h1001, 1);

        // Fixed sel=3 with channel 3 idle: no grant, held beat drains
        mode = 1'b0; sel = 2'd3; in_valid = 4'b0111;
        #1 check("fix3_ready", 32'(in_ready), 32'h0);
        step();
        check_out("fix3_drain", 0, 32'h1001, 1);

        // Reset while holding a beat; RR restarts at channel 0
        mode = 1'b1; in_valid = 4'hF;
        #1 check("rr_ptr2_ready", 32'(in_ready), 32'h4);
        step();
        check_out("pre_rst", 1, 32'h1002, 2);
        out_ready = 1'b0; rst = 1'b1;
        #1 check("rst_hold_ready", 32'(in_ready), 32'h0);
        step();
        check_out("mid_rst", 0, 0, 0);
        rst = 1'b0; out_ready = 1'b1;
        #1 check("rr_restart_ready", 32'(in_ready), 32'h1);
        step();
        check_out("rr_restart", 1, 32'h1000, 0);

        // Fixed mode must not move the RR pointer (still at 1)
        mode = 1'b0; sel = 2'd3;
        #1 check("fix_sel3_ready", 32'(in_ready), 32'h8);
        step();
        check_out("fix_sel3", 1, 32'h1003, 3);
        mode = 1'b1;
        #1 check("rr_ptr_kept", 32'(in_ready), 32'h2);
        in_valid = 4'h0;
        step();
        check("drain_valid", 32'(out_valid), 32'h0);

`ifdef STREAM_SELECT_MUX_PKT_LOCK_EN
        // Three-beat packet from ch1 with ch0/ch2 competing, then ch2
        mode = 1'b1; in_valid = 4'b0111;
        for (int k = 0; k < 3; k++) begin
            in_last = (k == 2) ? 4'b0010 : 4'b0000;
            #1 check("lock_ready", 32'(in_ready), 32'h2);
            step();
            check_out("lock", 1, 32'h1001, 1);
            check("lock_last", 32'(out_last), (k == 2) ? 32'h1 : 32'h0);
        end
        in_last = 4'h0;
        #1 check("unlock_ready", 32'(in_ready), 32'h4);
        step();
        check_out("unlock", 1, 32'h1002, 2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
